// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: lets N_REQ requesters share one W x W unsigned multiplier.
// A round-robin arbiter accepts one operand pair at a time and registers it onto
// the multiplier inputs. MUL_LAT edges later the product is captured. It is then
// returned on a single response channel, tagged with the id of the requester served.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for any req_valid; req_ready offered to the RR winner
// S_WAIT | operands on mul_x/mul_y; counting down the multiplier latency
// S_RESP | product held on rsp_* until the consumer takes it
module mult_share_arbiter #(
    parameter int N_REQ   = 2,
    parameter int W       = 4,
    parameter int MUL_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_x,
    input  logic [N_REQ*W-1:0] req_y,
    output logic [W-1:0]       mul_x,
    output logic [W-1:0]       mul_y,
    input  logic [2*W-1:0]     mul_z,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*W-1:0]     rsp_data,
    output logic [1:0]         rsp_id,
    output logic               busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter is loaded with MUL_LAT-1 so the product is sampled exactly
    // MUL_LAT edges after the operands were registered.
    localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT - 1);
    // Last grant starts at the top index, so requester 0 is searched first.
    localparam logic [1:0] LAST_RST = 2'(N_REQ - 1);

    logic [1:0]     state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [1:0]     last_grant_q, last_grant_d;
    logic [W-1:0]   mul_x_q, mul_x_d;
    logic [W-1:0]   mul_y_q, mul_y_d;
    logic [2*W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]     rsp_id_q, rsp_id_d;
    logic           rsp_valid_q, rsp_valid_d;

    logic           grant_found;
    logic [1:0]     grant_idx;
    logic [2:0]     cand;
    logic [3:0]     valid_ext;
    logic [W-1:0]   x_sel;
    logic [W-1:0]   y_sel;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 3'd0;
        valid_ext   = 4'(req_valid);
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_grant_q} + 3'(k);
            if (cand >= 3'(N_REQ)) begin
                cand = cand - 3'(N_REQ);
            end
            if (!grant_found && valid_ext[cand[1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[1:0];
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == 2'(i)) begin
                x_sel = req_x[i*W +: W];
                y_sel = req_y[i*W +: W];
            end
        end
    end

    // Accept is offered only while idle, one-hot to the round-robin winner.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found) begin
            req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
        end
    end

    // Next-state and datapath update for the IDLE/WAIT/RESP sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mul_x_d      = mul_x_q;
        mul_y_d      = mul_y_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    mul_x_d      = x_sel;
                    mul_y_d      = y_sel;
                    rsp_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = CNT_LOAD;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rsp_data_d  = mul_z;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= LAST_RST;
            mul_x_q      <= '0;
            mul_y_q      <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 2'd0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mul_x_q      <= mul_x_d;
            mul_y_q      <= mul_y_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: two instances (MUL_LAT=1 and MUL_LAT=3) run in
// lockstep on the same stimulus. Each instance is compared every cycle against
// its own transaction-level reference model.
module tb_mult_share_arbiter;

    localparam int N_REQ = 2;
    localparam int W     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_x;
    logic [N_REQ*W-1:0] req_y;
    logic               rsp_ready;

    logic [N_REQ-1:0]   req_ready [2];
    logic [W-1:0]       mul_x     [2];
    logic [W-1:0]       mul_y     [2];
    logic [2*W-1:0]     mul_z     [2];
    logic               rsp_valid [2];
    logic [2*W-1:0]     rsp_data  [2];
    logic [1:0]         rsp_id    [2];
    logic               busy      [2];

    mult_share_arbiter #(.N_REQ(N_REQ), .W(W), .MUL_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_x(req_x), .req_y(req_y), .mul_x(mul_x[0]), .mul_y(mul_y[0]),
        .mul_z(mul_z[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data[0]), .rsp_id(rsp_id[0]), .busy(busy[0])
    );

    mult_share_arbiter #(.N_REQ(N_REQ), .W(W), .MUL_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_x(req_x), .req_y(req_y), .mul_x(mul_x[1]), .mul_y(mul_y[1]),
        .mul_z(mul_z[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data[1]), .rsp_id(rsp_id[1]), .busy(busy[1])
    );

    // Bench multipliers: combinational for latency 1, two pipeline stages for latency 3.
    logic [2*W-1:0] pipe1, pipe2;
    assign mul_z[0] = 8'(mul_x[0]) * 8'(mul_y[0]);
    always @(posedge clk) begin
        pipe1 <= 8'(mul_x[1]) * 8'(mul_y[1]);
        pipe2 <= pipe1;
    end
    assign mul_z[1] = pipe2;

    // Reference model: one outstanding job per instance, with the edge index at which
    // its response becomes visible.
    int lat    [2] = '{1, 3};
    bit m_pend [2];
    int m_due  [2];
    int m_last [2];
    int m_prod [2];
    int m_id   [2];
    int m_x    [2];
    int m_y    [2];
    int cyc;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int opnd(input logic [N_REQ*W-1:0] bus, input int idx);
        return int'(bus[idx*W +: W]);
    endfunction

    // First valid requester after the last grant, or -1.
    function automatic int rr_pick(input int k);
        int c;
        for (int j = 1; j <= N_REQ; j++) begin
            c = (m_last[k] + j) % N_REQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 1'b0;
            m_last[k] = N_REQ - 1;
            m_x[k]    = 0;
            m_y[k]    = 0;
        end
    endtask

    // Check outputs mid-cycle, advance the model for the coming edge, then cross it.
    task automatic step();
        int g;
        bit vis;
        int exp_ready;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            g   = rr_pick(k);
            vis = m_pend[k] && (cyc >= m_due[k]);
            exp_ready = (!m_pend[k] && g >= 0) ? (1 << g) : 0;
            check_eq($sformatf("req_ready[L%0d]", lat[k]), int'(req_ready[k]), exp_ready);
            check_eq($sformatf("busy[L%0d]", lat[k]), int'(busy[k]), int'(m_pend[k]));
            check_eq($sformatf("rsp_valid[L%0d]", lat[k]), int'(rsp_valid[k]), int'(vis));
            check_eq($sformatf("mul_x[L%0d]", lat[k]), int'(mul_x[k]), m_x[k]);
            check_eq($sformatf("mul_y[L%0d]", lat[k]), int'(mul_y[k]), m_y[k]);
            if (vis) begin
                check_eq($sformatf("rsp_data[L%0d]", lat[k]), int'(rsp_data[k]), m_prod[k]);
                check_eq($sformatf("rsp_id[L%0d]", lat[k]), int'(rsp_id[k]), m_id[k]);
            end
            if (rst) begin
                m_pend[k] = 1'b0;
                m_last[k] = N_REQ - 1;
                m_x[k]    = 0;
                m_y[k]    = 0;
            end else if (!m_pend[k] && g >= 0) begin
                m_pend[k] = 1'b1;
                m_due[k]  = cyc + 1 + lat[k];
                m_x[k]    = opnd(req_x, g);
                m_y[k]    = opnd(req_y, g);
                m_prod[k] = m_x[k] * m_y[k];
                m_id[k]   = g;
                m_last[k] = g;
            end else if (vis && rsp_ready) begin
                m_pend[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_pend[0] || m_pend[1]) && n < 40) begin
            step();
            n++;
        end
        if (m_pend[0] || m_pend[1]) check_eq("drain_timeout", 1, 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        cyc       = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        step();
        rst = 1'b0;
        step();

        // Single request 3x5 from requester 0.
        req_valid = 2'b01; req_x = {4'd0, 4'd3}; req_y = {4'd0, 4'd5};
        step();
        req_valid = 2'b00;
        drain();
        step();

        // Both requesters held valid: grants alternate.
        req_valid = 2'b11; req_x = {4'd2, 4'd15}; req_y = {4'd7, 4'd15};
        repeat (40) step();
        req_valid = 2'b00;
        drain();

        // Consumer stalls the response.
        req_valid = 2'b01; req_x = {4'd0, 4'd6}; req_y = {4'd0, 4'd7};
        step();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        repeat (9) step();
        rsp_ready = 1'b1;
        drain();

        // 9x11 through both latencies.
        req_valid = 2'b01; req_x = {4'd0, 4'd9}; req_y = {4'd0, 4'd11};
        step();
        req_valid = 2'b00;
        drain();

        // Reset while waiting on the multiplier.
        req_valid = 2'b10; req_x = {4'd13, 4'd0}; req_y = {4'd12, 4'd0};
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 2'b11;
        step();
        req_valid = 2'b00;
        drain();

        // Exhaustive operand sweep on requester 1.
        for (int p = 0; p < 256; p++) begin
            req_valid = 2'b10;
            req_x = {4'(p >> 4), 4'(p)};
            req_y = {4'(p), 4'(p >> 4)};
            step();
            req_valid = 2'b00;
            drain();
        end

        // Random traffic with occasional resets and consumer stalls.
        repeat (3000) begin
            req_valid = 2'($urandom);
            req_x     = 8'($urandom);
            req_y     = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst       = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        drain();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
